// File: rtl/memb_loader.sv
// Streams one DEPTH x DEPTH matrix of signed elements into B memory, one write per
// accepted beat, in row-major or column-major order selected at start.
module memb_loader #(
  parameter int unsigned BITS_AB = 8,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             transpose,
  input  logic                             abort,
  input  logic                             in_valid,
  input  logic signed [BITS_AB-1:0]        in_data,
  output logic                             in_ready,
  output logic                             WrEn,
  output logic        [$clog2(DEPTH)-1:0]  row,
  output logic        [$clog2(DEPTH)-1:0]  col,
  output logic signed [BITS_AB-1:0]        Bin,
  output logic                             busy,
  output logic                             done
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned NUM = DEPTH * DEPTH;
  localparam int unsigned CW  = $clog2(NUM) + 1;

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e                     state_q, state_d;
  logic [CW-1:0]              idx_q, idx_d;
  logic                       mode_q, mode_d;
  logic                       wr_en_q;
  logic [AW-1:0]              row_q, col_q;
  logic signed [BITS_AB-1:0]  bin_q;
  logic                       accept;
  logic [AW-1:0]              idx_lo, idx_hi;

  // Low index bits select within a line, high bits select the line.
  assign idx_lo = idx_q[AW-1:0];
  assign idx_hi = idx_q[2*AW-1:AW];
  assign accept = in_ready & in_valid;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mode_d   = mode_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d = StLoad;
          idx_d   = '0;
          mode_d  = transpose;
        end
      end
      StLoad: begin
        busy     = 1'b1;
        in_ready = !abort;
        if (abort) begin
          state_d = StIdle;
        end else if (in_valid) begin
          idx_d = idx_q + CW'(1);
          if (idx_q == CW'(NUM - 1)) state_d = StDone;
        end
      end
      StDone: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      mode_q  <= 1'b0;
      wr_en_q <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      bin_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      wr_en_q <= accept;
      if (accept) begin
        bin_q <= in_data;
        if (mode_q) begin
          row_q <= idx_lo;
          col_q <= idx_hi;
        end else begin
          row_q <= idx_hi;
          col_q <= idx_lo;
        end
      end
    end
  end

  assign WrEn = wr_en_q;
  assign row  = row_q;
  assign col  = col_q;
  assign Bin  = bin_q;

endmodule

// File: tb/tb_memb_loader.sv
// Directed bench for memb_loader at DEPTH=8: row/column order, bubbles, abort, reset.
module tb_memb_loader;

  logic              clk = 1'b0;
  logic              rst_n, start, transpose, abort, in_valid;
  logic signed [7:0] in_data;
  logic              in_ready, WrEn, busy, done;
  logic [2:0]        row, col;
  logic signed [7:0] Bin;

  int errors = 0;
  int checks = 0;

  memb_loader #(.BITS_AB(8), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .transpose(transpose), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .WrEn(WrEn),
    .row(row), .col(col), .Bin(Bin), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Write monitor, sampled on the falling edge.
  int         cyc = 0, wr_cnt = 0, done_cnt = 0, done_wr = -1, first_wr = 0, last_wr = 0;
  logic [2:0] log_row [128];
  logic [2:0] log_col [128];
  logic [7:0] log_bin [128];
  int         hits [8][8];
  logic [7:0] mem [8][8];
  logic       clear_req = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (clear_req) begin
      wr_cnt = 0; done_cnt = 0; done_wr = -1;
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++) begin
          hits[i][j] = 0;
          mem[i][j]  = 8'h00;
        end
    end else begin
      if (WrEn === 1'b1) begin
        if (wr_cnt < 128) begin
          log_row[wr_cnt] = row; log_col[wr_cnt] = col; log_bin[wr_cnt] = Bin;
        end
        hits[row][col]++;
        mem[row][col] = Bin;
        if (wr_cnt == 0) first_wr = cyc;
        last_wr = cyc;
        wr_cnt++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_wr = (WrEn === 1'b1) ? wr_cnt : -1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    clear_req = 1'b1;
    @(negedge clk);
    #1;
    clear_req = 1'b0;
  endtask

  // Start a load and feed beats k-32; returns 1 ns after the edge accepting the last beat.
  task automatic load(input bit tr, input int nbeats, input int bubble);
    int k = 0;
    int guard = 0;
    start = 1'b1; transpose = tr;
    tick();
    start = 1'b0; transpose = ~tr;
    while (k < nbeats && guard < 2000) begin
      in_valid = (bubble == 0) || ($urandom_range(99) >= bubble);
      in_data  = 8'(k - 32);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL load_in_ready: beat %0d got %b want 1", k, in_ready);
      end
      tick();
      if (in_valid) k++;
      guard++;
    end
    in_valid = 1'b0;
    if (guard >= 2000) begin
      errors++;
      $display("FAIL load_timeout: accepted %0d want %0d", k, nbeats);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; abort = 1'b1; in_valid = 1'b1; transpose = 1'b1;
    in_data = 8'h55;
    repeat (3) tick();
    checks++;
    if ({WrEn, row, col, Bin, done, busy, in_ready} !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", {WrEn, row, col, Bin, done, busy, in_ready});
    end
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; transpose = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({WrEn, row, col, Bin, done, busy, in_ready} !== 18'd0) begin
        errors++;
        $display("FAIL idle_outputs: cycle %0d got %h want 0", i,
                 {WrEn, row, col, Bin, done, busy, in_ready});
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_row_major();
    int bad = 0;
    clear_mon();
    load(1'b0, 64, 0);
    checks++;
    if ({WrEn, done, busy} !== 3'b111) begin
      errors++;
      $display("FAIL final_write_done: WrEn/done/busy got %b want 111", {WrEn, done, busy});
    end
    tick();
    checks++;
    if ({WrEn, done, busy} !== 3'b000) begin
      errors++;
      $display("FAIL after_done: WrEn/done/busy got %b want 000", {WrEn, done, busy});
    end
    checks++;
    if ({row, col, Bin} !== {3'd7, 3'd7, 8'd31}) begin
      errors++;
      $display("FAIL hold_outputs: row=%0d col=%0d Bin=%0d want 7 7 31", row, col, Bin);
    end
    tick();
    checks++;
    if (wr_cnt != 64 || last_wr - first_wr != 63) begin
      errors++;
      $display("FAIL rm_write_run: writes=%0d span=%0d want 64 63", wr_cnt, last_wr - first_wr);
    end
    checks++;
    if (done_cnt != 1 || done_wr != 64) begin
      errors++;
      $display("FAIL rm_done: count=%0d at_write=%0d want 1 64", done_cnt, done_wr);
    end
    checks++;
    if (log_row[9] !== 3'd1 || log_col[9] !== 3'd1 || log_bin[9] !== 8'hE9) begin
      errors++;
      $display("FAIL rm_beat9: row=%0d col=%0d Bin=%h want 1 1 e9",
               log_row[9], log_col[9], log_bin[9]);
    end
    for (int k = 0; k < 64; k++)
      if (log_row[k] !== 3'(k / 8) || log_col[k] !== 3'(k % 8) || log_bin[k] !== 8'(k - 32))
        bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rm_order: %0d beats misplaced want 0", bad);
    end
  endtask

  task automatic test_transpose();
    int bad = 0;
    clear_mon();
    load(1'b1, 64, 0);
    repeat (2) tick();
    checks++;
    if (log_row[1] !== 3'd1 || log_col[1] !== 3'd0) begin
      errors++;
      $display("FAIL tr_beat1: row=%0d col=%0d want 1 0", log_row[1], log_col[1]);
    end
    checks++;
    if (log_row[8] !== 3'd0 || log_col[8] !== 3'd1) begin
      errors++;
      $display("FAIL tr_beat8: row=%0d col=%0d want 0 1", log_row[8], log_col[8]);
    end
    checks++;
    if (log_row[63] !== 3'd7 || log_col[63] !== 3'd7 || wr_cnt != 64) begin
      errors++;
      $display("FAIL tr_final: row=%0d col=%0d writes=%0d want 7 7 64",
               log_row[63], log_col[63], wr_cnt);
    end
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (mem[i][j] !== 8'(j * 8 + i - 32)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL tr_readback: %0d cells wrong want 0", bad);
    end
  endtask

  task automatic test_bubbles();
    int bad = 0;
    clear_mon();
    load(1'b0, 64, 50);
    repeat (2) tick();
    checks++;
    if (wr_cnt != 64 || done_cnt != 1) begin
      errors++;
      $display("FAIL bub_counts: writes=%0d dones=%0d want 64 1", wr_cnt, done_cnt);
    end
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (hits[i][j] != 1 || mem[i][j] !== 8'(i * 8 + j - 32)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bub_cells: %0d cells wrong want 0", bad);
    end
  endtask

  task automatic test_abort();
    clear_mon();
    load(1'b0, 20, 0);
    abort = 1'b1; in_valid = 1'b1; in_data = 8'h7f;
    #1;
    checks++;
    if (in_ready !== 1'b0 || WrEn !== 1'b1) begin
      errors++;
      $display("FAIL abort_cycle: in_ready=%b WrEn=%b want 0 1", in_ready, WrEn);
    end
    tick();
    abort = 1'b0;
    #1;
    checks++;
    if ({busy, in_ready, WrEn} !== 3'b000) begin
      errors++;
      $display("FAIL abort_idle: busy/in_ready/WrEn got %b want 000", {busy, in_ready, WrEn});
    end
    in_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if (wr_cnt != 20 || done_cnt != 0) begin
      errors++;
      $display("FAIL abort_counts: writes=%0d dones=%0d want 20 0", wr_cnt, done_cnt);
    end
    clear_mon();
    load(1'b0, 64, 0);
    tick();
    checks++;
    if (log_row[0] !== 3'd0 || log_col[0] !== 3'd0 || log_bin[0] !== 8'he0 || wr_cnt != 64
        || done_cnt != 1) begin
      errors++;
      $display("FAIL reload: row=%0d col=%0d Bin=%h writes=%0d dones=%0d want 0 0 e0 64 1",
               log_row[0], log_col[0], log_bin[0], wr_cnt, done_cnt);
    end
  endtask

  task automatic test_abort_start_idle();
    int w0 = wr_cnt;
    start = 1'b1; abort = 1'b1; in_valid = 1'b1;
    repeat (2) tick();
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || wr_cnt != w0) begin
      errors++;
      $display("FAIL abort_wins: busy=%b in_ready=%b writes=%0d want 0 0 %0d",
               busy, in_ready, wr_cnt, w0);
    end
    start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    tick();
  endtask

  task automatic test_start_reset();
    clear_mon();
    load(1'b0, 15, 0);
    for (int j = 0; j < 15; j++) begin
      start = (j == 0); in_valid = 1'b1; in_data = 8'(15 + j - 32);
      tick();
      start = 1'b0;
      if (j == 0) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL start_ignored_busy: got %b want 1", busy);
        end
      end
    end
    rst_n = 1'b0; start = 1'b1; abort = 1'b1; in_valid = 1'b1;
    tick();
    checks++;
    if ({WrEn, row, col, Bin, done, busy, in_ready} !== 18'd0) begin
      errors++;
      $display("FAIL midload_reset: got %h want 0", {WrEn, row, col, Bin, done, busy, in_ready});
    end
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if (wr_cnt != 30 || done_cnt != 0) begin
      errors++;
      $display("FAIL midload_counts: writes=%0d dones=%0d want 30 0", wr_cnt, done_cnt);
    end
    checks++;
    if (log_row[16] !== 3'd2 || log_col[16] !== 3'd0 || log_row[29] !== 3'd3
        || log_col[29] !== 3'd5) begin
      errors++;
      $display("FAIL start_no_restart: b16=%0d,%0d b29=%0d,%0d want 2,0 3,5",
               log_row[16], log_col[16], log_row[29], log_col[29]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; transpose = 1'b0; abort = 1'b0; in_valid = 1'b0;
    in_data = 8'h00;
    test_reset();
    test_row_major();
    test_transpose();
    test_bubbles();
    test_abort();
    test_abort_start_idle();
    test_start_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memb_loader.md
MEMB_LOADER -- requirements
Module: memb_loader

Interface
REQ-001 Parameter BITS_AB, default 8, width of one signed B-matrix element.
REQ-002 Parameter DEPTH, default 8, matrix dimension (DEPTH x DEPTH); power of two, >= 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 start  input  1  request to load one full matrix; sampled in IDLE only.
REQ-006 transpose  input  1  stream order select, sampled with accepted start: 0 row-major, 1 column-major.
REQ-007 abort  input  1  terminate current load; return to IDLE.
REQ-008 in_valid  input  1  upstream element valid.
REQ-009 in_data  input  BITS_AB  signed upstream element.
REQ-010 in_ready  output  1  loader accepts element this cycle.
REQ-011 WrEn  output  1  write strobe to B memory.
REQ-012 row  output  $clog2(DEPTH)  B memory write row.
REQ-013 col  output  $clog2(DEPTH)  B memory write column.
REQ-014 Bin  output  BITS_AB  signed write data to B memory.
REQ-015 busy  output  1  high in LOAD and DONE.
REQ-016 done  output  1  one-cycle pulse: full matrix written.

Function
REQ-017 FSM states IDLE, LOAD, DONE; single state register.
REQ-018 IDLE -> LOAD when start=1 and abort=0; element counter idx cleared to 0; transpose latched into mode register.
REQ-019 in_ready = 1 only in LOAD and abort=0; combinational from state and abort.
REQ-020 Beat accepted when in_valid=1 and in_ready=1; no acceptance otherwise; in_data ignored when not accepted.
REQ-021 Per accepted beat, next cycle: WrEn=1, Bin=in_data, row/col from idx (1-cycle latency, registered outputs).
REQ-022 Mode 0: row=idx/DEPTH, col=idx%DEPTH; mode 1: row=idx%DEPTH, col=idx/DEPTH.
REQ-023 idx increments by 1 per accepted beat; range 0..DEPTH*DEPTH-1; counter width $clog2(DEPTH*DEPTH)+1, no wrap within a load.
REQ-024 Accepted beat with idx=DEPTH*DEPTH-1: LOAD -> DONE.
REQ-025 DONE: done=1 for exactly one cycle, concurrent with final WrEn; DONE -> IDLE unconditionally next cycle.
REQ-026 Cycles without acceptance: WrEn=0; row, col, Bin hold last values.
REQ-027 in_valid gaps (bubbles) of any length in LOAD tolerated; no element skipped or duplicated.
REQ-028 start asserted in LOAD or DONE ignored; no restart, no state change.
REQ-029 transpose changes after start accepted have no effect until next load.
REQ-030 abort=1 in LOAD: no beat accepted that cycle; next state IDLE; done not asserted; WrEn from a beat accepted the previous cycle still issued.
REQ-031 abort=1 in DONE: no effect; done pulse completes.
REQ-032 abort=1 with start=1 in IDLE: abort wins; remain IDLE.
REQ-033 Bin carries in_data bit-exact; no sign extension, saturation or arithmetic.

Reset
REQ-034 rst_n=0 at rising edge: state IDLE, idx=0, mode=0, WrEn=0, row=0, col=0, Bin=0, done=0; busy=0 and in_ready=0.
REQ-035 Reset mid-load discards partial progress; no done, no further WrEn after reset edge.
REQ-036 Reset dominates start, abort and in_valid in the same cycle.

Verification
REQ-037 Reset then idle: all outputs 0, in_ready=0 for 10 cycles with in_valid=1.
REQ-038 DEPTH=8, start, transpose=0, 64 back-to-back beats value k-32 for k=0..63 -> 64 consecutive WrEn; beat 9 at row=1,col=1,Bin=-23; done on cycle of 64th WrEn; busy low next cycle.
REQ-039 transpose=1, same stream -> beat 1 at row=1,col=0; beat 8 at row=0,col=1; final at row=7,col=7; memB readback equals transposed matrix.
REQ-040 Random in_valid bubbles (~50%) during load -> exactly 64 WrEn, each (row,col) written once, done once.
REQ-041 abort after 20 accepted beats -> state IDLE, no done, in_ready=0; new start reloads from row=0,col=0.
REQ-042 start pulsed mid-load and rst_n low after 30 beats -> start ignored, reset clears outputs to 0, no done.
